// File: rtl/spi_axi_ctrl_if.sv
// AXI4-Lite bus bundle used between the SPI frame engine and the
// register fabric; master side is the frame engine.
interface spi_axi_ctrl_if #(
    parameter int C_ADDR_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/spi_axi_ctrl.sv
// SPI frame protocol engine: decodes command/address bytes, assembles
// write words, issues AXI4-Lite reads/writes and streams read data back.
module spi_axi_ctrl #(
    parameter int C_ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_first,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_load,
    input  logic                  err_clr,
    output logic                  err_late,
    output logic                  err_overrun,
    output logic                  err_resp,
    output logic                  busy,
    spi_axi_ctrl_if.master        m_axi
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] DUMMY = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;

    localparam logic [2:0] A_IDLE = 3'd0;
    localparam logic [2:0] A_AW_W = 3'd1;
    localparam logic [2:0] A_B    = 3'd2;
    localparam logic [2:0] A_AR   = 3'd3;
    localparam logic [2:0] A_R    = 3'd4;

    logic [2:0]  f_state_q, f_state_d;
    logic        rw_q, rw_d;
    logic [14:0] waddr_q, waddr_d;
    logic [23:0] wbuf_q, wbuf_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        wr_issued_q, wr_issued_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] rword_q, rword_d;

    logic [2:0]  a_state_q, a_state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [14:0] ax_addr_q, ax_addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        pend_q, pend_d;
    logic        pend_rd_q, pend_rd_d;
    logic [14:0] pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;

    logic        err_late_q, err_late_d;
    logic        err_overrun_q, err_overrun_d;
    logic        err_resp_q, err_resp_d;

    logic        iss_wr, iss_rd;
    logic [14:0] iss_addr;
    logic [31:0] iss_data;
    logic        set_late, set_ovr, set_resp;
    logic        rd_busy, wr_busy;
    logic        launch, l_rd;
    logic [14:0] l_addr;
    logic [31:0] l_data;

    // A read or write is in flight or queued behind the current transaction
    assign rd_busy = (pend_q && pend_rd_q) ||
                     (a_state_q == A_AR) || (a_state_q == A_R);
    assign wr_busy = (pend_q && !pend_rd_q) ||
                     (a_state_q == A_AW_W) || (a_state_q == A_B);

    // Frame decoder: command/address bytes, write assembly, read byte stepping
    always_comb begin
        f_state_d   = f_state_q;
        rw_d        = rw_q;
        waddr_d     = waddr_q;
        wbuf_d      = wbuf_q;
        wcnt_d      = wcnt_q;
        wr_issued_d = wr_issued_q;
        byte_idx_d  = byte_idx_q;
        iss_wr      = 1'b0;
        iss_rd      = 1'b0;
        iss_addr    = waddr_q;
        iss_data    = {wbuf_q, rx_data};
        set_late    = 1'b0;
        set_ovr     = 1'b0;
        if (rx_valid && rx_first) begin
            f_state_d   = ADDR;
            rw_d        = rx_data[7];
            waddr_d     = {rx_data[6:0], waddr_q[7:0]};
            wcnt_d      = 2'd0;
            wr_issued_d = 1'b0;
            byte_idx_d  = 2'd0;
        end else if (rx_first) begin
            f_state_d = IDLE;
        end else begin
            unique case (f_state_q)
                ADDR: begin
                    if (rx_valid) begin
                        waddr_d = {waddr_q[14:8], rx_data};
                        wcnt_d  = 2'd0;
                        if (rw_q) begin
                            f_state_d = DUMMY;
                            iss_rd    = 1'b1;
                            iss_addr  = {waddr_q[14:8], rx_data};
                        end else begin
                            f_state_d = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        wbuf_d = {wbuf_q[15:0], rx_data};
                        wcnt_d = wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) begin
                            waddr_d = waddr_q + 15'd1;
                            if (wr_issued_q && wr_busy) begin
                                set_ovr = 1'b1;
                            end else begin
                                iss_wr      = 1'b1;
                                wr_issued_d = 1'b1;
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (tx_load) begin
                        f_state_d  = RDATA;
                        byte_idx_d = 2'd0;
                    end
                end
                RDATA: begin
                    if (tx_load) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (rd_busy) begin
                            set_late = 1'b1;
                        end
                        if (byte_idx_q == 2'd3) begin
                            waddr_d  = waddr_q + 15'd1;
                            iss_rd   = 1'b1;
                            iss_addr = waddr_q + 15'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // AXI sub-FSM: launches queued or fresh requests and tracks handshakes
    always_comb begin
        a_state_d   = a_state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        ax_addr_d   = ax_addr_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q;
        pend_rd_d   = pend_rd_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        rword_d     = rword_q;
        set_resp    = 1'b0;
        launch      = 1'b0;
        l_rd        = iss_rd;
        l_addr      = iss_addr;
        l_data      = iss_data;
        unique case (a_state_q)
            A_IDLE: begin
                if (pend_q) begin
                    launch = 1'b1;
                    l_rd   = pend_rd_q;
                    l_addr = pend_addr_q;
                    l_data = pend_data_q;
                    pend_d = 1'b0;
                end else if (iss_wr || iss_rd) begin
                    launch = 1'b1;
                end
            end
            A_AW_W: begin
                if (m_axi.awready) begin
                    awvalid_d = 1'b0;
                end
                if (m_axi.wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    a_state_d = A_B;
                    bready_d  = 1'b1;
                end
            end
            A_B: begin
                if (m_axi.bvalid) begin
                    a_state_d = A_IDLE;
                    bready_d  = 1'b0;
                    set_resp  = (m_axi.bresp != 2'b00);
                end
            end
            A_AR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    a_state_d = A_R;
                end
            end
            A_R: begin
                if (m_axi.rvalid) begin
                    rready_d  = 1'b0;
                    a_state_d = A_IDLE;
                    rword_d   = m_axi.rdata;
                    set_resp  = (m_axi.rresp != 2'b00);
                end
            end
            default: a_state_d = A_IDLE;
        endcase
        if ((iss_wr || iss_rd) && !(a_state_q == A_IDLE && !pend_q)) begin
            pend_d      = 1'b1;
            pend_rd_d   = iss_rd;
            pend_addr_d = iss_addr;
            pend_data_d = iss_data;
        end
        if (launch) begin
            ax_addr_d = l_addr;
            wdata_d   = l_data;
            if (l_rd) begin
                arvalid_d = 1'b1;
                a_state_d = A_AR;
            end else begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                a_state_d = A_AW_W;
            end
        end
        if (iss_rd) begin
            rword_d = 32'hFFFF_FFFF;
        end
    end

    // Sticky error flags; a new set wins over a same-cycle clear
    always_comb begin
        err_late_d    = set_late | (err_late_q & ~err_clr);
        err_overrun_d = set_ovr  | (err_overrun_q & ~err_clr);
        err_resp_d    = set_resp | (err_resp_q & ~err_clr);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            f_state_q     <= IDLE;
            rw_q          <= 1'b0;
            waddr_q       <= '0;
            wbuf_q        <= '0;
            wcnt_q        <= '0;
            wr_issued_q   <= 1'b0;
            byte_idx_q    <= '0;
            rword_q       <= 32'hFFFF_FFFF;
            a_state_q     <= A_IDLE;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            ax_addr_q     <= '0;
            wdata_q       <= '0;
            pend_q        <= 1'b0;
            pend_rd_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            err_late_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            err_resp_q    <= 1'b0;
        end else begin
            f_state_q     <= f_state_d;
            rw_q          <= rw_d;
            waddr_q       <= waddr_d;
            wbuf_q        <= wbuf_d;
            wcnt_q        <= wcnt_d;
            wr_issued_q   <= wr_issued_d;
            byte_idx_q    <= byte_idx_d;
            rword_q       <= rword_d;
            a_state_q     <= a_state_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            ax_addr_q     <= ax_addr_d;
            wdata_q       <= wdata_d;
            pend_q        <= pend_d;
            pend_rd_q     <= pend_rd_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            err_late_q    <= err_late_d;
            err_overrun_q <= err_overrun_d;
            err_resp_q    <= err_resp_d;
        end
    end

    // MISO byte: big-endian slice of the read word while streaming data
    always_comb begin
        tx_data = 8'h00;
        if (f_state_q == RDATA) begin
            unique case (byte_idx_q)
                2'd0: tx_data = rword_q[31:24];
                2'd1: tx_data = rword_q[23:16];
                2'd2: tx_data = rword_q[15:8];
                2'd3: tx_data = rword_q[7:0];
                default: tx_data = 8'h00;
            endcase
        end
    end

    assign err_late    = err_late_q;
    assign err_overrun = err_overrun_q;
    assign err_resp    = err_resp_q;
    assign busy        = (f_state_q != IDLE) || (a_state_q != A_IDLE) || pend_q;

    assign m_axi.awaddr  = C_ADDR_WIDTH'({ax_addr_q, 2'b00});
    assign m_axi.araddr  = C_ADDR_WIDTH'({ax_addr_q, 2'b00});
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_spi_axi_ctrl.sv
// Directed bench for spi_axi_ctrl: byte-level SPI driver plus a small
// AXI4-Lite slave with configurable stalls and error responses.
module tb_spi_axi_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_first = 1'b1;
    logic       rx_valid = 1'b0;
    logic       tx_load = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] tx_data;
    logic       err_late, err_overrun, err_resp, busy;

    spi_axi_ctrl_if #(.C_ADDR_WIDTH(32)) axi ();

    spi_axi_ctrl #(.C_ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_first    (rx_first),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .err_clr     (err_clr),
        .err_late    (err_late),
        .err_overrun (err_overrun),
        .err_resp    (err_resp),
        .busy        (busy),
        .m_axi       (axi.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration and logs
    logic        b_hold = 1'b0;
    logic        ar_stall = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] rmem [0:31];
    logic [31:0] aw_log [0:15];
    logic [31:0] w_log [0:15];
    logic [3:0]  s_log [0:15];
    logic [31:0] ar_log [0:15];
    int          aw_cnt = 0;
    int          w_cnt = 0;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    logic        r_pend = 1'b0;
    logic [31:0] r_addr = '0;

    // AXI4-Lite slave model
    always @(posedge clk) begin
        if (rst) begin
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= 2'b00;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= 2'b00;
            r_pend      <= 1'b0;
            r_cnt       <= 0;
        end else begin
            axi.awready <= axi.awvalid && !axi.awready;
            axi.wready  <= axi.wvalid && !axi.wready;
            axi.bvalid  <= axi.bready && !axi.bvalid && !b_hold;
            axi.bresp   <= bresp_cfg;
            axi.arready <= axi.arvalid && !axi.arready && !ar_stall;
            if (axi.awvalid && axi.awready) begin
                aw_log[aw_cnt[3:0]] <= axi.awaddr;
                aw_cnt <= aw_cnt + 1;
            end
            if (axi.wvalid && axi.wready) begin
                w_log[w_cnt[3:0]] <= axi.wdata;
                s_log[w_cnt[3:0]] <= axi.wstrb;
                w_cnt <= w_cnt + 1;
            end
            if (axi.arvalid && axi.arready) begin
                ar_log[ar_cnt[3:0]] <= axi.araddr;
                ar_cnt <= ar_cnt + 1;
                r_pend <= 1'b1;
                r_cnt  <= 2;
                r_addr <= axi.araddr;
            end else if (r_pend) begin
                if (r_cnt != 0) begin
                    r_cnt <= r_cnt - 1;
                end else if (!axi.rvalid) begin
                    axi.rvalid <= 1'b1;
                    axi.rdata  <= rmem[r_addr[6:2]];
                    axi.rresp  <= 2'b00;
                end else if (axi.rready) begin
                    axi.rvalid <= 1'b0;
                    r_pend     <= 1'b0;
                end
            end
        end
    end

    // one SPI byte: load MISO at start, deliver MOSI at end
    task automatic xfer(input logic [7:0] mosi, input logic first,
                        output logic [7:0] miso);
        @(negedge clk);
        rx_first = first;
        tx_load = 1'b1;
        miso = tx_data;
        @(negedge clk);
        tx_load = 1'b0;
        repeat (8) @(negedge clk);
        rx_data = mosi;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_first = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        rx_first = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy timeout: got %b want 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (axi.awvalid !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid got %b want 0", axi.awvalid); end
        n_cmp++; if (axi.wvalid !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid got %b want 0", axi.wvalid); end
        n_cmp++; if (axi.arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got %b want 0", axi.arvalid); end
        n_cmp++; if (axi.bready !== 1'b0) begin n_bad++; $display("FAIL rst_bready got %b want 0", axi.bready); end
        n_cmp++; if (axi.rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready got %b want 0", axi.rready); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx got %h want 00", tx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if ({err_late, err_overrun, err_resp} !== 3'b000) begin n_bad++; $display("FAIL rst_err got %b want 000", {err_late, err_overrun, err_resp}); end
        n_cmp++; if (axi.awprot !== 3'b000) begin n_bad++; $display("FAIL rst_awprot got %b want 000", axi.awprot); end
        n_cmp++; if (axi.wstrb !== 4'hF) begin n_bad++; $display("FAIL rst_wstrb got %h want f", axi.wstrb); end
    endtask

    task automatic test_write();
        logic [7:0] b;
        int a0;
        int w0;
        logic [7:0] fr [0:5];
        a0 = aw_cnt;
        w0 = w_cnt;
        fr = '{8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 6; i++) xfer(fr[i], (i == 0), b);
        frame_end();
        wait_idle("write");
        n_cmp++; if (aw_cnt - a0 !== 1) begin n_bad++; $display("FAIL wr_awcnt got %0d want 1", aw_cnt - a0); end
        n_cmp++; if (w_cnt - w0 !== 1) begin n_bad++; $display("FAIL wr_wcnt got %0d want 1", w_cnt - w0); end
        n_cmp++; if (aw_log[a0[3:0]] !== 32'h40) begin n_bad++; $display("FAIL wr_awaddr got %h want 00000040", aw_log[a0[3:0]]); end
        n_cmp++; if (w_log[w0[3:0]] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_wdata got %h want deadbeef", w_log[w0[3:0]]); end
        n_cmp++; if (s_log[w0[3:0]] !== 4'hF) begin n_bad++; $display("FAIL wr_wstrb got %h want f", s_log[w0[3:0]]); end
        n_cmp++; if ({err_late, err_overrun, err_resp} !== 3'b000) begin n_bad++; $display("FAIL wr_err got %b want 000", {err_late, err_overrun, err_resp}); end
    endtask

    task automatic test_read();
        logic [7:0] b;
        logic [7:0] exp [0:7];
        int r0;
        r0 = ar_cnt;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rmem[2] = 32'h11223344;
        rmem[3] = 32'h55667788;
        rmem[4] = 32'h99AABBCC;
        xfer(8'h80, 1'b1, b);
        xfer(8'h02, 1'b0, b);
        xfer(8'h00, 1'b0, b);
        n_cmp++; if (b !== 8'h00) begin n_bad++; $display("FAIL rd_dummy got %h want 00", b); end
        for (int i = 0; i < 8; i++) begin
            xfer(8'h00, 1'b0, b);
            n_cmp++;
            if (b !== exp[i]) begin
                n_bad++;
                $display("FAIL rd_byte%0d got %h want %h", i, b, exp[i]);
            end
        end
        frame_end();
        wait_idle("read");
        n_cmp++; if (ar_cnt - r0 !== 3) begin n_bad++; $display("FAIL rd_arcnt got %0d want 3", ar_cnt - r0); end
        n_cmp++; if (ar_log[r0[3:0]] !== 32'h08) begin n_bad++; $display("FAIL rd_araddr0 got %h want 00000008", ar_log[r0[3:0]]); end
        n_cmp++; if (ar_log[4'(r0 + 1)] !== 32'h0C) begin n_bad++; $display("FAIL rd_araddr1 got %h want 0000000c", ar_log[4'(r0 + 1)]); end
        n_cmp++; if (err_late !== 1'b0) begin n_bad++; $display("FAIL rd_late got %b want 0", err_late); end
    endtask

    task automatic test_late();
        logic [7:0] b;
        rmem[5] = 32'hA1B2C3D4;
        ar_stall = 1'b1;
        xfer(8'h80, 1'b1, b);
        xfer(8'h05, 1'b0, b);
        xfer(8'h00, 1'b0, b);
        xfer(8'h00, 1'b0, b);
        n_cmp++; if (b !== 8'hFF) begin n_bad++; $display("FAIL late_byte got %h want ff", b); end
        n_cmp++; if (err_late !== 1'b1) begin n_bad++; $display("FAIL late_flag got %b want 1", err_late); end
        ar_stall = 1'b0;
        repeat (12) @(negedge clk);
        xfer(8'h00, 1'b0, b);
        n_cmp++; if (b !== 8'hB2) begin n_bad++; $display("FAIL late_next got %h want b2", b); end
        frame_end();
        wait_idle("late");
        n_cmp++; if (err_late !== 1'b1) begin n_bad++; $display("FAIL late_sticky got %b want 1", err_late); end
        pulse_clr();
        n_cmp++; if (err_late !== 1'b0) begin n_bad++; $display("FAIL late_clr got %b want 0", err_late); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        int a0;
        int w0;
        a0 = aw_cnt;
        w0 = w_cnt;
        b_hold = 1'b1;
        xfer(8'h00, 1'b1, b);
        xfer(8'h20, 1'b0, b);
        for (int i = 1; i <= 8; i++) xfer(8'(i), 1'b0, b);
        frame_end();
        n_cmp++; if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", err_overrun); end
        n_cmp++; if (aw_cnt - a0 !== 1) begin n_bad++; $display("FAIL ovr_awcnt got %0d want 1", aw_cnt - a0); end
        n_cmp++; if (w_cnt - w0 !== 1) begin n_bad++; $display("FAIL ovr_wcnt got %0d want 1", w_cnt - w0); end
        n_cmp++; if (w_log[w0[3:0]] !== 32'h01020304) begin n_bad++; $display("FAIL ovr_wdata got %h want 01020304", w_log[w0[3:0]]); end
        b_hold = 1'b0;
        wait_idle("overrun");
        pulse_clr();
        n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr got %b want 0", err_overrun); end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        int a0;
        int w0;
        a0 = aw_cnt;
        w0 = w_cnt;
        bresp_cfg = 2'b10;
        xfer(8'h7F, 1'b1, b);
        xfer(8'hFF, 1'b0, b);
        for (int i = 0; i < 8; i++) xfer(8'hA0 + 8'(i), 1'b0, b);
        frame_end();
        wait_idle("wrap");
        bresp_cfg = 2'b00;
        n_cmp++; if (aw_cnt - a0 !== 2) begin n_bad++; $display("FAIL wrap_awcnt got %0d want 2", aw_cnt - a0); end
        n_cmp++; if (aw_log[a0[3:0]] !== 32'h1FFFC) begin n_bad++; $display("FAIL wrap_addr0 got %h want 0001fffc", aw_log[a0[3:0]]); end
        n_cmp++; if (aw_log[4'(a0 + 1)] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr1 got %h want 00000000", aw_log[4'(a0 + 1)]); end
        n_cmp++; if (w_log[4'(w0 + 1)] !== 32'hA4A5A6A7) begin n_bad++; $display("FAIL wrap_wdata1 got %h want a4a5a6a7", w_log[4'(w0 + 1)]); end
        n_cmp++; if (err_resp !== 1'b1) begin n_bad++; $display("FAIL wrap_resp got %b want 1", err_resp); end
        n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL wrap_ovr got %b want 0", err_overrun); end
        pulse_clr();
        n_cmp++; if (err_resp !== 1'b0) begin n_bad++; $display("FAIL wrap_clr got %b want 0", err_resp); end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        logic [7:0] exp [0:3];
        int a0;
        int r0;
        a0 = aw_cnt;
        exp = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        xfer(8'h00, 1'b1, b);
        xfer(8'h05, 1'b0, b);
        xfer(8'hAA, 1'b0, b);
        xfer(8'hBB, 1'b0, b);
        frame_end();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (aw_cnt - a0 !== 0) begin n_bad++; $display("FAIL abort_awcnt got %0d want 0", aw_cnt - a0); end
        r0 = ar_cnt;
        rmem[3] = 32'hCAFEF00D;
        xfer(8'h80, 1'b1, b);
        xfer(8'h03, 1'b0, b);
        xfer(8'h00, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, 1'b0, b);
            n_cmp++;
            if (b !== exp[i]) begin
                n_bad++;
                $display("FAIL abort_rd%0d got %h want %h", i, b, exp[i]);
            end
        end
        frame_end();
        wait_idle("abort");
        n_cmp++; if (ar_log[r0[3:0]] !== 32'h0C) begin n_bad++; $display("FAIL abort_araddr got %h want 0000000c", ar_log[r0[3:0]]); end
        n_cmp++; if (aw_cnt - a0 !== 0) begin n_bad++; $display("FAIL abort_awcnt2 got %0d want 0", aw_cnt - a0); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rmem[i] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_late();
        test_overrun();
        test_wrap();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
